hashtable_lookup_ctrl: RTL and testbench

Front-end controller for the per-subset segment hash table RAM (16-bit address, 12-bit entry: bits 10:0 segment index, bit 11 big/small segment flag). It accepts classification lookup keys and rule-update writes on two valid/ready channels and arbitrates them onto the single table port. It captures the one-cycle read data into a 2-entry result buffer under credit-based flow control and presents decoded results to the downstream segment-table stage.

---
 rtl/hashtable_lookup_ctrl.sv | 156 +++++++++++++++
 tb/tb_hashtable_lookup_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hashtable_lookup_ctrl.sv
// rtl/hashtable_lookup_ctrl.sv - segment hash table lookup/update front-end with 2-entry result buffer
//
// Arbitrates lookup keys and rule-update writes onto the single hash table port.
// Read data is captured one cycle after issue into a 2-entry FIFO, with issue
// gated by credits so that the FIFO can never overflow.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   lkp_valid/lkp_ready/key/tag    lookup request channel
//   upd_valid/upd_ready/addr/data  table update channel
//   ht_addr/ht_we/ht_din/ht_dout   single-port table RAM (1-cycle read latency)
//   res_valid/res_ready/tag/addr/index/big   decoded result channel
//   upd_cnt                        completed update writes (wrapping)
module hashtable_lookup_ctrl #(
  parameter int HASHTABLE_ENTRY_BIT_LEN = 12,
  parameter int KEY_LEN                 = 32,
  parameter int TAG_LEN                 = 8,
  parameter int STARVE_LIMIT            = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               lkp_valid,
  output logic                               lkp_ready,
  input  logic [KEY_LEN-1:0]                 lkp_key,
  input  logic [TAG_LEN-1:0]                 lkp_tag,
  input  logic                               upd_valid,
  output logic                               upd_ready,
  input  logic [15:0]                        upd_addr,
  input  logic [HASHTABLE_ENTRY_BIT_LEN-1:0] upd_data,
  output logic [15:0]                        ht_addr,
  output logic                               ht_we,
  output logic [HASHTABLE_ENTRY_BIT_LEN-1:0] ht_din,
  input  logic [HASHTABLE_ENTRY_BIT_LEN-1:0] ht_dout,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [TAG_LEN-1:0]                 res_tag,
  output logic [15:0]                        res_addr,
  output logic [HASHTABLE_ENTRY_BIT_LEN-2:0] res_index,
  output logic                               res_big,
  output logic [15:0]                        upd_cnt
);

  localparam int EW = HASHTABLE_ENTRY_BIT_LEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] L_LIMIT = SW'(STARVE_LIMIT);

  // Result FIFO and read pipeline state
  logic [1:0]         r_occ;
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic               r_inflight;
  logic [TAG_LEN-1:0] r_pipe_tag;
  logic [15:0]        r_pipe_addr;
  logic [TAG_LEN-1:0] r_buf_tag  [0:1];
  logic [15:0]        r_buf_addr [0:1];
  logic [EW-1:0]      r_buf_data [0:1];

  logic [SW-1:0]      r_starve_cnt;
  logic [15:0]        r_upd_cnt;

  logic               w_pop;
  logic [2:0]         w_pend;
  logic               w_credit;
  logic               w_starve_max;
  logic               w_starve_hold;
  logic               w_upd_grant;
  logic               w_lkp_grant;
  logic [15:0]        w_key_addr;

  assign res_valid  = (r_occ != 2'd0);
  assign w_pop      = res_valid & res_ready;
  assign w_key_addr = lkp_key[KEY_LEN-1 -: 16];

  // Entries that will occupy the FIFO next cycle if nothing new is issued now;
  // a read issued now lands one cycle later, so at most one more slot is allowed.
  assign w_pend   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit = rst_n & (w_pend < 3'd2);

  // Starvation override: after STARVE_LIMIT update grants a waiting, issuable
  // lookup takes the port and updates are held off for that cycle.
  assign w_starve_max  = (r_starve_cnt == L_LIMIT);
  assign w_starve_hold = w_starve_max & lkp_valid & w_credit;

  assign w_upd_grant = rst_n & upd_valid & ~w_starve_hold;
  assign w_lkp_grant = rst_n & lkp_valid & w_credit & ~w_upd_grant;

  // lkp_ready is independent of lkp_valid: a pending update blocks it unless
  // the starvation counter has saturated.
  assign upd_ready = rst_n & ~w_starve_hold;
  assign lkp_ready = w_credit & ~(upd_valid & ~w_starve_max);

  always_comb begin
    ht_we   = 1'b0;
    ht_addr = 16'h0000;
    ht_din  = '0;
    if (w_upd_grant) begin
      ht_we   = 1'b1;
      ht_addr = upd_addr;
      ht_din  = upd_data;
    end else if (w_lkp_grant) begin
      ht_addr = w_key_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ        <= 2'd0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_inflight   <= 1'b0;
      r_pipe_tag   <= '0;
      r_pipe_addr  <= 16'h0000;
      r_starve_cnt <= '0;
      r_upd_cnt    <= 16'h0000;
    end else begin
      r_inflight <= w_lkp_grant;
      if (w_lkp_grant) begin
        r_pipe_tag  <= lkp_tag;
        r_pipe_addr <= w_key_addr;
      end
      if (r_inflight) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

      if (w_lkp_grant || !lkp_valid) begin
        r_starve_cnt <= '0;
      end else if (w_upd_grant && w_credit && !w_starve_max) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      if (w_upd_grant) begin
        r_upd_cnt <= r_upd_cnt + 16'h0001;
      end
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (rst_n && r_inflight) begin
      r_buf_tag[r_wr_ptr]  <= r_pipe_tag;
      r_buf_addr[r_wr_ptr] <= r_pipe_addr;
      r_buf_data[r_wr_ptr] <= ht_dout;
    end
  end

  assign res_tag   = r_buf_tag[r_rd_ptr];
  assign res_addr  = r_buf_addr[r_rd_ptr];
  assign res_index = r_buf_data[r_rd_ptr][EW-2:0];
  assign res_big   = r_buf_data[r_rd_ptr][EW-1];
  assign upd_cnt   = r_upd_cnt;

endmodule

// File: tb/tb_hashtable_lookup_ctrl.sv
// tb/tb_hashtable_lookup_ctrl.sv - directed self-checking bench for hashtable_lookup_ctrl
module tb_hashtable_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lkp_valid;
  logic        lkp_ready;
  logic [31:0] lkp_key;
  logic [7:0]  lkp_tag;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_addr;
  logic [11:0] upd_data;
  logic [15:0] ht_addr;
  logic        ht_we;
  logic [11:0] ht_din;
  logic [11:0] ht_dout;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_tag;
  logic [15:0] res_addr;
  logic [10:0] res_index;
  logic        res_big;
  logic [15:0] upd_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hashtable_lookup_ctrl #(
    .HASHTABLE_ENTRY_BIT_LEN(12),
    .KEY_LEN(32),
    .TAG_LEN(8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key), .lkp_tag(lkp_tag),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_data(upd_data),
    .ht_addr(ht_addr), .ht_we(ht_we), .ht_din(ht_din), .ht_dout(ht_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_addr(res_addr),
    .res_index(res_index), .res_big(res_big), .upd_cnt(upd_cnt)
  );

  // Table model: unwritten entries read back a fixed pattern of their address.
  logic            tb_init;
  logic [11:0]     mem [0:65535];
  logic [65535:0]  wr_map;

  function automatic logic [11:0] tbl_init(input logic [15:0] a);
    if (a == 16'hABCD) return 12'h87F;
    return a[11:0] ^ {a[15:12], 8'h00};
  endfunction

  always @(posedge clk) begin
    if (tb_init) begin
      wr_map <= '0;
    end else if (ht_we) begin
      mem[ht_addr]    <= ht_din;
      wr_map[ht_addr] <= 1'b1;
    end
    ht_dout <= wr_map[ht_addr] ? mem[ht_addr] : tbl_init(ht_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    int nu;
    int nl;
    logic exp_u;

    rst_n = 1'b0; tb_init = 1'b1;
    lkp_valid = 1'b0; lkp_key = '0; lkp_tag = '0;
    upd_valid = 1'b1; upd_addr = 16'h0077; upd_data = 12'h111;
    res_ready = 1'b1;

    // Reset gating and reset state
    nxt(); #1;
    chk("rst_upd_ready", 32'(upd_ready), 32'd0);
    chk("rst_lkp_ready", 32'(lkp_ready), 32'd0);
    chk("rst_ht_we",     32'(ht_we),     32'd0);
    nxt(); tb_init = 1'b0; rst_n = 1'b1; upd_valid = 1'b0; #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_upd_cnt",   32'(upd_cnt),   32'd0);

    // Write then read-after-write on the next cycle
    nxt(); upd_valid = 1'b1; upd_addr = 16'h0010; upd_data = 12'h123; #1;
    chk("wr_upd_ready", 32'(upd_ready), 32'd1);
    chk("wr_ht_we",     32'(ht_we),     32'd1);
    chk("wr_ht_addr",   32'(ht_addr),   32'h0010);
    chk("wr_ht_din",    32'(ht_din),    32'h123);
    nxt(); upd_valid = 1'b0; lkp_valid = 1'b1; lkp_key = 32'h0010_0000; lkp_tag = 8'h33; #1;
    chk("raw_upd_cnt",   32'(upd_cnt),   32'd1);
    chk("raw_lkp_ready", 32'(lkp_ready), 32'd1);
    chk("raw_ht_addr",   32'(ht_addr),   32'h0010);
    nxt(); lkp_valid = 1'b0; #1;
    chk("raw_res_n1", 32'(res_valid), 32'd0);
    nxt(); #1;
    chk("raw_res_valid", 32'(res_valid), 32'd1);
    chk("raw_res_index", 32'(res_index), 32'h123);
    chk("raw_res_big",   32'(res_big),   32'd0);
    chk("raw_res_tag",   32'(res_tag),   32'h33);
    chk("raw_res_addr",  32'(res_addr),  32'h0010);
    nxt(); #1;
    chk("raw_res_drained", 32'(res_valid), 32'd0);

    // Single lookup: result two cycles after acceptance
    nxt(); lkp_valid = 1'b1; lkp_key = 32'hABCD_1234; lkp_tag = 8'h05; #1;
    chk("one_lkp_ready", 32'(lkp_ready), 32'd1);
    chk("one_ht_addr",   32'(ht_addr),   32'hABCD);
    chk("one_ht_we",     32'(ht_we),     32'd0);
    nxt(); lkp_valid = 1'b0; #1;
    chk("one_res_n1", 32'(res_valid), 32'd0);
    nxt(); #1;
    chk("one_res_valid", 32'(res_valid), 32'd1);
    chk("one_res_addr",  32'(res_addr),  32'hABCD);
    chk("one_res_index", 32'(res_index), 32'h07F);
    chk("one_res_big",   32'(res_big),   32'd1);
    chk("one_res_tag",   32'(res_tag),   32'h05);
    nxt(); #1;
    chk("one_res_drained", 32'(res_valid), 32'd0);

    // 8 back-to-back lookups, results on consecutive cycles in order
    for (int c = 0; c < 10; c++) begin
      nxt();
      lkp_valid = (c < 8);
      lkp_key   = {16'h0100 + 16'(c), 16'h0000};
      lkp_tag   = 8'h10 + 8'(c);
      #1;
      if (c < 8) chk("b2b_lkp_ready", 32'(lkp_ready), 32'd1);
      chk("b2b_res_valid", 32'(res_valid), 32'(c >= 2));
      if (c >= 2) begin
        chk("b2b_res_tag",   32'(res_tag),   32'h10 + 32'(c - 2));
        chk("b2b_res_index", 32'(res_index), 32'h100 + 32'(c - 2));
      end
    end
    lkp_valid = 1'b0;
    nxt(); #1;
    chk("b2b_drained", 32'(res_valid), 32'd0);

    // Backpressure: exactly two accepted while res_ready=0, then drain in order
    res_ready = 1'b0;
    nl = 0;
    for (int c = 0; c < 6; c++) begin
      nxt();
      lkp_valid = 1'b1;
      lkp_key   = {16'h0200 + 16'(nl), 16'h0000};
      lkp_tag   = 8'h20 + 8'(nl);
      #1;
      chk("bp_lkp_ready", 32'(lkp_ready), 32'(c < 2));
      chk("bp_res_valid", 32'(res_valid), 32'(c >= 2));
      if (c >= 2) chk("bp_res_tag_hold", 32'(res_tag), 32'h20);
      if (c < 2) nl++;
    end
    nxt(); lkp_valid = 1'b0; res_ready = 1'b1; #1;
    chk("bp_drain0_valid", 32'(res_valid), 32'd1);
    chk("bp_drain0_tag",   32'(res_tag),   32'h20);
    chk("bp_drain0_index", 32'(res_index), 32'h200);
    nxt(); #1;
    chk("bp_drain1_valid", 32'(res_valid), 32'd1);
    chk("bp_drain1_tag",   32'(res_tag),   32'h21);
    chk("bp_drain1_index", 32'(res_index), 32'h201);
    nxt(); #1;
    chk("bp_drained", 32'(res_valid), 32'd0);

    // Starvation: 4 update grants then 1 lookup grant, repeating
    nu = 0; nl = 0;
    for (int c = 0; c < 13; c++) begin
      nxt();
      upd_valid = (c < 10);
      upd_addr  = 16'h0400 + 16'(nu);
      upd_data  = 12'h800 | 12'(nu);
      lkp_valid = (c < 10);
      lkp_key   = {16'h0400 + 16'(nu) - 16'h0001, 16'h0000};
      lkp_tag   = 8'h40 + 8'(nl);
      #1;
      exp_u = (c < 10) && ((c % 5) != 4);
      chk("st_ht_we", 32'(ht_we), 32'(exp_u));
      if (c < 10) begin
        chk("st_upd_ready", 32'(upd_ready), 32'(exp_u));
        chk("st_lkp_ready", 32'(lkp_ready), 32'(!exp_u));
      end
      chk("st_res_valid", 32'(res_valid), 32'((c == 6) || (c == 11)));
      if (c == 6 || c == 11) begin
        chk("st_res_tag",   32'(res_tag),   (c == 6) ? 32'h40 : 32'h41);
        chk("st_res_index", 32'(res_index), (c == 6) ? 32'h003 : 32'h007);
        chk("st_res_big",   32'(res_big),   32'd1);
      end
      if (exp_u) nu++;
      if ((c < 10) && !exp_u) nl++;
    end
    chk("st_upd_cnt", 32'(upd_cnt), 32'd9);

    // Reset with one buffered result and one read inflight
    res_ready = 1'b0;
    nxt(); lkp_valid = 1'b1; lkp_key = 32'h0500_0000; lkp_tag = 8'h50; #1;
    chk("mr_lkp0_ready", 32'(lkp_ready), 32'd1);
    nxt(); lkp_key = 32'h0501_0000; lkp_tag = 8'h51; #1;
    chk("mr_lkp1_ready", 32'(lkp_ready), 32'd1);
    nxt(); lkp_valid = 1'b0; rst_n = 1'b0; upd_valid = 1'b1; #1;
    chk("mr_pre_res_valid", 32'(res_valid), 32'd1);
    chk("mr_lkp_ready",     32'(lkp_ready), 32'd0);
    chk("mr_upd_ready",     32'(upd_ready), 32'd0);
    chk("mr_ht_we",         32'(ht_we),     32'd0);
    nxt(); rst_n = 1'b1; upd_valid = 1'b0; res_ready = 1'b1; #1;
    chk("mr_res_valid", 32'(res_valid), 32'd0);
    chk("mr_upd_cnt",   32'(upd_cnt),   32'd0);
    for (int c = 0; c < 3; c++) begin
      nxt(); #1;
      chk("mr_no_spurious", 32'(res_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
